// File: rtl/intc_vec.sv
// Vectored interrupt controller: synchronised edge detection, maskable pending bits, fixed lowest-index priority.
// Build option INTC_LEVEL_EN adds a TRIGGER register (offset 4) that makes selected channels level-sensitive.
module intc_vec #(
  parameter int                N_IRQ     = 8,
  parameter int                DATA_W    = 8,
  parameter int                ADDR_W    = 16,
  parameter logic [ADDR_W-1:0] BASE_ADDR = 16'hFF00,
  parameter int                ID_W      = (N_IRQ > 1) ? $clog2(N_IRQ) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [N_IRQ-1:0]  irq_in,
  input  logic              sel,
  input  logic              rd,
  input  logic              wr,
  input  logic [ADDR_W-1:0] dir,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              irq_req,
  input  logic              irq_ack,
  output logic [ID_W-1:0]   irq_id,
  output logic              in_service
);

  // state  | meaning
  // S_IDLE | no request outstanding, waiting for an eligible channel
  // S_REQ  | irq_req high, irq_id frozen until irq_ack
  // S_SVC  | handler running, waiting for an EOI write
  typedef enum logic [1:0] {S_IDLE, S_REQ, S_SVC} state_t;

  localparam logic [ADDR_W-1:0] OFF_PEND = ADDR_W'(0);
  localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] OFF_VEC  = ADDR_W'(2);
  localparam logic [ADDR_W-1:0] OFF_EOI  = ADDR_W'(3);
`ifdef INTC_LEVEL_EN
  localparam logic [ADDR_W-1:0] OFF_TRIG = ADDR_W'(4);
  localparam logic [ADDR_W-1:0] N_WORDS  = ADDR_W'(5);
`else
  localparam logic [ADDR_W-1:0] N_WORDS  = ADDR_W'(4);
`endif

  state_t             r_state, w_state_nxt;
  logic [N_IRQ-1:0]   r_sync1, r_sync2, r_sync_prev;
  logic [N_IRQ-1:0]   r_pend, r_mask;
  logic [ID_W-1:0]    r_irq_id;
  logic [N_IRQ-1:0]   w_edge, w_elig, w_w1c, w_ack_clr, w_pend_nxt;
  logic [ID_W-1:0]    w_win_id;
  logic               w_any;
  logic [ADDR_W-1:0]  w_off;
  logic               w_in_win, w_wr, w_ack_ok;
  logic [DATA_W-1:0]  w_rdata;
`ifdef INTC_LEVEL_EN
  logic [N_IRQ-1:0]   r_trig;
`endif

  assign w_off    = dir - BASE_ADDR;
  assign w_in_win = sel && (w_off < N_WORDS);
  assign w_wr     = w_in_win && wr;
  assign w_edge   = r_sync2 & ~r_sync_prev;
  assign w_elig   = r_pend & r_mask;
  assign w_any    = |w_elig;
  assign w_ack_ok = (r_state == S_REQ) && irq_ack;
  assign w_w1c    = (w_wr && (w_off == OFF_PEND)) ? wdata[N_IRQ-1:0] : '0;

  always_comb begin
    w_ack_clr = '0;
    if (w_ack_ok) w_ack_clr[r_irq_id] = 1'b1;
  end

  // A fresh edge wins over a same-cycle W1C or acknowledge clear.
  always_comb begin
    w_pend_nxt = (r_pend & ~w_w1c & ~w_ack_clr) | w_edge;
`ifdef INTC_LEVEL_EN
    w_pend_nxt = (w_pend_nxt & ~r_trig) | (r_sync2 & r_trig);
`endif
  end

  always_comb begin
    w_win_id = '0;
    for (int i = N_IRQ - 1; i >= 0; i--) begin
      if (w_elig[i]) w_win_id = ID_W'(i);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sync1     <= '0;
      r_sync2     <= '0;
      r_sync_prev <= '0;
      r_pend      <= '0;
      r_mask      <= '0;
      r_irq_id    <= '0;
    end else begin
      r_sync1     <= irq_in;
      r_sync2     <= r_sync1;
      r_sync_prev <= r_sync2;
      r_pend      <= w_pend_nxt;
      if (w_wr && (w_off == OFF_MASK)) r_mask <= wdata[N_IRQ-1:0];
      if ((r_state == S_IDLE) && w_any) r_irq_id <= w_win_id;
    end
  end

`ifdef INTC_LEVEL_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_trig <= '0;
    else if (w_wr && (w_off == OFF_TRIG)) r_trig <= wdata[N_IRQ-1:0];
  end
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_any) w_state_nxt = S_REQ;
      S_REQ:   if (irq_ack) w_state_nxt = S_SVC;
      S_SVC:   if (w_wr && (w_off == OFF_EOI)) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_rdata = '0;
    if (w_in_win && rd) begin
      case (w_off)
        OFF_PEND: w_rdata[N_IRQ-1:0] = r_pend;
        OFF_MASK: w_rdata[N_IRQ-1:0] = r_mask;
        OFF_VEC:  w_rdata[ID_W-1:0]  = r_irq_id;
`ifdef INTC_LEVEL_EN
        OFF_TRIG: w_rdata[N_IRQ-1:0] = r_trig;
`endif
        default:  w_rdata = '0;
      endcase
    end
  end

  assign rdata      = w_rdata;
  assign irq_req    = (r_state == S_REQ);
  assign in_service = (r_state == S_SVC);
  assign irq_id     = r_irq_id;

endmodule

// File: tb/tb_intc_vec.sv
// Directed bench for intc_vec: reset, latency, priority, masking, W1C/edge collision, trigger mode.
module tb_intc_vec;

  localparam logic [15:0] BASE = 16'hFF00;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [7:0]  irq_in = '0;
  logic        sel = 1'b0, rd = 1'b0, wr = 1'b0;
  logic [15:0] dir = '0;
  logic [7:0]  wdata = '0;
  logic [7:0]  rdata;
  logic        irq_req;
  logic        irq_ack = 1'b0;
  logic [2:0]  irq_id;
  logic        in_service;

  int checks = 0;
  int errors = 0;
  logic [31:0] v;

  intc_vec dut (
    .clk(clk), .reset(reset), .irq_in(irq_in), .sel(sel), .rd(rd), .wr(wr),
    .dir(dir), .wdata(wdata), .rdata(rdata), .irq_req(irq_req), .irq_ack(irq_ack),
    .irq_id(irq_id), .in_service(in_service)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic bus_wr(input logic [15:0] off, input logic [7:0] d);
    sel = 1'b1; wr = 1'b1; dir = BASE + off; wdata = d;
    @(posedge clk); #1;
    sel = 1'b0; wr = 1'b0;
  endtask

  task automatic bus_rd(input logic [15:0] off, output logic [31:0] d);
    sel = 1'b1; rd = 1'b1; dir = BASE + off;
    #1;
    d = 32'(rdata);
    sel = 1'b0; rd = 1'b0;
  endtask

  task automatic ack();
    irq_ack = 1'b1;
    tick(1);
    irq_ack = 1'b0;
  endtask

  initial begin
    // Reset values
    tick(3);
    check("rst_req", 32'(irq_req), 0);
    check("rst_id", 32'(irq_id), 0);
    check("rst_svc", 32'(in_service), 0);
    check("rst_rdata", 32'(rdata), 0);
    reset = 1'b1;
    tick(1);

    // Reset while servicing channel 2
    bus_wr(1, 8'hFF);
    sel = 1'b0; rd = 1'b1; dir = BASE + 16'd1; #1;
    check("rdata_unsel", 32'(rdata), 0);
    rd = 1'b0;
    irq_in[2] = 1'b1;
    tick(4);
    check("ch2_req", 32'(irq_req), 1);
    check("ch2_id", 32'(irq_id), 2);
    ack();
    irq_in[2] = 1'b0;
    check("ch2_svc", 32'(in_service), 1);
    reset = 1'b0; #1;
    check("mid_rst_req", 32'(irq_req), 0);
    check("mid_rst_id", 32'(irq_id), 0);
    check("mid_rst_svc", 32'(in_service), 0);
    tick(1);
    reset = 1'b1;
    tick(1);
    bus_rd(1, v); check("mid_rst_mask", v, 0);
    bus_rd(0, v); check("mid_rst_pend", v, 0);

    // Four-cycle latency on channel 5, three-cycle pulse
    bus_wr(1, 8'hFF);
    irq_in[5] = 1'b1;
    tick(3);
    irq_in[5] = 1'b0;
    check("lat_req_early", 32'(irq_req), 0);
    tick(1);
    check("lat_req", 32'(irq_req), 1);
    check("lat_id", 32'(irq_id), 5);
    bus_rd(2, v); check("vector", v, 5);
    ack();
    check("ack_req", 32'(irq_req), 0);
    check("ack_svc", 32'(in_service), 1);
    bus_rd(0, v); check("ack_pend", v, 0);
    bus_rd(3, v); check("eoi_reads0", v, 0);
    bus_wr(3, 8'h00);
    check("eoi_svc", 32'(in_service), 0);
    tick(1);
    check("eoi_noreq", 32'(irq_req), 0);

    // Priority: channels 6 and 1 together
    irq_in[6] = 1'b1; irq_in[1] = 1'b1;
    tick(4);
    irq_in = '0;
    check("prio_req", 32'(irq_req), 1);
    check("prio_id1", 32'(irq_id), 1);
    ack();
    bus_wr(3, 8'h00);
    check("prio_eoi_req", 32'(irq_req), 0);
    tick(1);
    check("prio_req6", 32'(irq_req), 1);
    check("prio_id6", 32'(irq_id), 6);
    ack();
    bus_wr(3, 8'h00);
    tick(1);
    check("prio_done", 32'(irq_req), 0);

    // Masked channel 3, then unmask
    bus_wr(1, 8'h00);
    irq_in[3] = 1'b1;
    tick(2);
    irq_in[3] = 1'b0;
    tick(2);
    bus_rd(0, v); check("mask_pend", v, 32'h08);
    check("mask_noreq", 32'(irq_req), 0);
    bus_wr(1, 8'h08);
    check("unmask_req_early", 32'(irq_req), 0);
    tick(1);
    check("unmask_req", 32'(irq_req), 1);
    check("unmask_id", 32'(irq_id), 3);
    ack();
    bus_wr(3, 8'h00);

    // Edge-set and W1C on the same bit in the same cycle
    bus_wr(1, 8'h00);
    irq_in[2] = 1'b1;
    tick(4);
    irq_in[2] = 1'b0;
    tick(3);
    bus_rd(0, v); check("coll_pre", v, 32'h04);
    irq_in[2] = 1'b1;
    tick(2);
    bus_wr(0, 8'h04);
    bus_rd(0, v); check("coll_setwins", v, 32'h04);
    irq_in[2] = 1'b0;
    tick(3);
    bus_wr(0, 8'h04);
    bus_rd(0, v); check("w1c_clear", v, 0);
    bus_rd(7, v); check("unmapped", v, 0);

`ifdef INTC_LEVEL_EN
    // Level-sensitive channel 0 keeps re-requesting while held high
    bus_wr(4, 8'h01);
    bus_rd(4, v); check("trig_rd", v, 32'h01);
    bus_wr(1, 8'h01);
    irq_in[0] = 1'b1;
    tick(4);
    check("lvl_req", 32'(irq_req), 1);
    ack();
    bus_wr(3, 8'h00);
    tick(1);
    check("lvl_rereq", 32'(irq_req), 1);
    irq_in[0] = 1'b0;
    tick(4);
    ack();
    bus_wr(3, 8'h00);
    tick(2);
    check("lvl_done", 32'(irq_req), 0);
`else
    // Without the level option, offset 4 is inert and a held line requests once
    bus_wr(4, 8'h01);
    bus_rd(4, v); check("trig_rd0", v, 0);
    bus_wr(1, 8'h01);
    irq_in[0] = 1'b1;
    tick(4);
    check("edge_req", 32'(irq_req), 1);
    ack();
    bus_wr(3, 8'h00);
    tick(2);
    check("edge_once", 32'(irq_req), 0);
    irq_in[0] = 1'b0;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/intc_vec.md
# intc_vec

Parametrised vectored interrupt controller placed between external interrupt lines and the CPU core. It replaces the fixed 3‑line raw interrupt input with N synchronised, maskable, priority‑encoded channels. The CPU reads and writes its registers over the same rd/wr/dir/data I/O bus used for peripherals. It drives a single request/acknowledge handshake plus the winning channel ID into the control unit.

## Interface
- N_IRQ, 8: number of interrupt channels, 1..DATA_W.
- DATA_W, 8: I/O data bus width.
- ADDR_W, 16: I/O address width.
- BASE_ADDR, 16'hFF00: base address of the register window (4 words; 5 with INTC_LEVEL_EN).
- ID_W, $clog2(N_IRQ) (min 1): width of irq_id.

Ports:
- clk  in  1  system clock, all state on rising edge.
- reset  in  1  asynchronous, active‑low; clears all state.
- irq_in  in  N_IRQ  raw asynchronous interrupt lines.
- sel  in  1  bus cycle enable (Wishbone‑style strobe).
- rd  in  1  read strobe, qualified by sel.
- wr  in  1  write strobe, qualified by sel.
- dir  in  ADDR_W  bus address.
- wdata  in  DATA_W  write data.
- rdata  out  DATA_W  read data; combinational, 0 when not selected.
- irq_req  out  1  interrupt request to control unit.
- irq_ack  in  1  one‑cycle acknowledge from control unit.
- irq_id  out  ID_W  channel being requested/serviced.
- in_service  out  1  high between acknowledge and EOI.

## Operation
- Register map (offset from BASE_ADDR): 0 PENDING (R; write‑1‑to‑clear), 1 MASK (R/W, 1 = enabled), 2 VECTOR (R; {zero‑ext irq_id}), 3 EOI (W any value; reads 0).
- Bits above N_IRQ read 0, writes ignored. Unmapped offsets read 0.
- Each irq_in bit passes a 2‑flop synchroniser, then a rising‑edge detector (sync vs. previous sync). A detected edge sets PENDING[i].
- Eligible = PENDING & MASK. Priority fixed: lowest index wins.
- FSM:
  - IDLE: irq_req=0, in_service=0. If Eligible≠0, latch the winner into irq_id and go to REQ.
  - REQ: irq_req=1. irq_id is frozen; MASK/PENDING changes do not withdraw the request. On irq_ack, clear PENDING[irq_id] and go to SVC.
  - SVC: irq_req=0, in_service=1. On an EOI write, go to IDLE.
- No nesting: new edges only set PENDING while in REQ or SVC.
- Ignored events: EOI write in IDLE/REQ; irq_ack in IDLE/SVC.
- Simultaneous events on the same bit in the same cycle (set wins in both cases):
  - edge‑set and W1C write;
  - edge‑set and ack‑clear.
- Reset at any point: FSM to IDLE; PENDING, MASK, sync/edge flops, irq_id all 0.

## Timing
- Reset values: rdata=0, irq_req=0, irq_id=0, in_service=0; MASK=0, so all channels are disabled.
- Latency: irq_in rises before edge 1 → sync at edges 1,2 → PENDING set at edge 3 → irq_req high after edge 4 (4 cycles).
- irq_ack sampled high at edge k: irq_req low and in_service high after edge k.
- EOI write at edge k: in_service low after k. If Eligible≠0, irq_req high again after k+1.
- Register writes take effect at the edge where sel&wr is sampled. Reads are combinational in the same cycle.
- An input pulse must stay high ≥2 clk cycles to be guaranteed to be caught.

## Configuration
- Macro INTC_LEVEL_EN.
- Defined:
  - Adds TRIGGER register at offset 4 (R/W, reset 0). TRIGGER[i]=1 makes channel i level‑sensitive.
  - For a level‑sensitive channel, PENDING[i] equals the synchronised input each cycle. W1C and ack‑clear have no lasting effect, so the ISR must clear the source.
- Undefined: offset 4 reads 0 and writes are ignored; all channels are edge‑triggered.

## Test plan
- Reset mid‑SVC (irq_id=2, in_service=1): assert reset → all outputs 0, MASK reads 0x00, PENDING reads 0x00.
- MASK=0xFF, pulse irq_in[5] for 3 cycles → irq_req high 4 cycles after the rise, irq_id=5, VECTOR reads 0x05. Ack → PENDING reads 0x00, in_service=1. EOI → in_service=0.
- MASK=0xFF, raise irq_in[6] and irq_in[1] together → irq_id=1. Ack, EOI → irq_req high again next cycle with irq_id=6.
- MASK=0x00, pulse irq_in[3] → PENDING=0x08, irq_req stays 0. Write MASK=0x08 → irq_req high after 1 cycle, irq_id=3.
- PENDING=0x04 with edge on irq_in[2] in the same cycle as a W1C write of 0x04 → PENDING stays 0x04.
- INTC_LEVEL_EN defined: TRIGGER=0x01, MASK=0x01, hold irq_in[0] high. Ack, EOI → irq_req reasserts until irq_in[0] is lowered; with TRIGGER=0 only one request occurs.
